// File: rtl/kv_wb_dcache.sv
// kv_wb_dcache: blocking, write-back, write-allocate, set-associative data cache.
// One request is handled at a time; misses walk an explicit state machine
// (optional victim write-back, then line fetch, then response).
// Ports:
//   i_clk, i_rstn                  clock (rising edge), asynchronous active-low reset
//   i_req_* / o_req_ready          load/store request (we, word address, wdata, byte strobes)
//   o_rsp_valid/o_rsp_data/i_rsp_ready  response word (loads: read data, stores: merged word)
//   o_fetch_valid/o_fetch_addr/i_fetch_ready  line-fetch request to memory
//   i_fetch_valid/i_fetch_data/o_fetch_ready  fetched line from memory
//   o_line_valid/o_line_addr/o_line_data/i_line_ready  dirty victim write-back
//   o_hit_count/o_miss_count       wrapping counters of accepted hits / misses
module kv_wb_dcache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAY_NUM    = 2,
  parameter int LINE_SIZE  = 4,
  parameter int LINE_NUM   = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_we,
  input  logic [ADDR_WIDTH-1:0]           i_req_addr,
  input  logic [DATA_WIDTH-1:0]           i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]         i_req_strb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  output logic                            o_fetch_valid,
  input  logic                            i_fetch_ready,
  output logic [ADDR_WIDTH-1:0]           o_fetch_addr,
  input  logic                            i_fetch_valid,
  output logic                            o_fetch_ready,
  input  logic [DATA_WIDTH*LINE_SIZE-1:0] i_fetch_data,
  output logic                            o_line_valid,
  input  logic                            i_line_ready,
  output logic [ADDR_WIDTH-1:0]           o_line_addr,
  output logic [DATA_WIDTH*LINE_SIZE-1:0] o_line_data,
  output logic [31:0]                     o_hit_count,
  output logic [31:0]                     o_miss_count
);

  localparam int LOW   = $clog2(LINE_SIZE);
  localparam int SETS  = LINE_NUM / WAY_NUM;
  localparam int IDXW  = $clog2(SETS);
  localparam int TAGW  = ADDR_WIDTH - LOW - IDXW;
  localparam int WAYW  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int SLOTW = $clog2(LINE_NUM);
  localparam int STRBW = DATA_WIDTH / 8;
  localparam int LINEW = DATA_WIDTH * LINE_SIZE;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOOKUP     = 3'd1,
    S_WRITEBACK  = 3'd2,
    S_FETCH_REQ  = 3'd3,
    S_FETCH_WAIT = 3'd4,
    S_RESPOND    = 3'd5
  } state_e;

  // Flat storage slot for (way, set); with one way the way bit is dropped.
  function automatic logic [SLOTW-1:0] slot_of(input logic [WAYW-1:0] way, input logic [IDXW-1:0] idx);
    return SLOTW'({way, idx});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] word_of(input logic [LINEW-1:0] line, input logic [LOW-1:0] off);
    logic [DATA_WIDTH-1:0] w;
    w = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < LINE_SIZE; i++) w = (off == LOW'(i)) ? line[i*DATA_WIDTH +: DATA_WIDTH] : w;
    return w;
  endfunction

  function automatic logic [LINEW-1:0] put_word(input logic [LINEW-1:0] line, input logic [LOW-1:0] off,
                                                input logic [DATA_WIDTH-1:0] word);
    logic [LINEW-1:0] l;
    l = line;
    for (int i = 0; i < LINE_SIZE; i++) l[i*DATA_WIDTH +: DATA_WIDTH] = (off == LOW'(i)) ? word : l[i*DATA_WIDTH +: DATA_WIDTH];
    return l;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [STRBW-1:0] strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < STRBW; b++) r[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [LINE_NUM-1:0]     valid_q, dirty_q;
  logic [TAGW-1:0]         tag_q  [LINE_NUM];
  logic [LINEW-1:0]        data_q [LINE_NUM];
  logic [WAYW-1:0]         ptr_q;
  logic                    req_we_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;
  logic [STRBW-1:0]        req_strb_q;
  logic [SLOTW-1:0]        vic_slot_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [ADDR_WIDTH-1:0]   line_addr_q;
  logic [LINEW-1:0]        line_data_q;
  logic [31:0]             hit_cnt_q, miss_cnt_q;

  logic [LOW-1:0]          off_s;
  logic [IDXW-1:0]         idx_s;
  logic [TAGW-1:0]         tag_s;
  logic                    hit_s, inv_found_s, vic_dirty_s;
  logic [WAYW-1:0]         hit_way_s, inv_way_s, vic_way_s;
  logic [SLOTW-1:0]        hit_slot_s, vic_slot_s;
  logic [LINEW-1:0]        hit_line_s, fill_line_s;
  logic [DATA_WIDTH-1:0]   hit_old_s, hit_word_s, fill_old_s, fill_word_s;

  assign off_s = req_addr_q[LOW-1:0];
  assign idx_s = req_addr_q[LOW +: IDXW];
  assign tag_s = req_addr_q[ADDR_WIDTH-1 -: TAGW];

  // Tag compare across ways; descending scan so the lowest invalid way wins.
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = {WAYW{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {WAYW{1'b0}};
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      hit_way_s   = (valid_q[slot_of(WAYW'(w), idx_s)] && (tag_q[slot_of(WAYW'(w), idx_s)] == tag_s)) ? WAYW'(w) : hit_way_s;
      hit_s       = hit_s | (valid_q[slot_of(WAYW'(w), idx_s)] && (tag_q[slot_of(WAYW'(w), idx_s)] == tag_s));
      inv_way_s   = (!valid_q[slot_of(WAYW'(w), idx_s)]) ? WAYW'(w) : inv_way_s;
      inv_found_s = inv_found_s | !valid_q[slot_of(WAYW'(w), idx_s)];
    end
  end

  assign vic_way_s   = inv_found_s ? inv_way_s : ptr_q;
  assign vic_slot_s  = slot_of(vic_way_s, idx_s);
  assign hit_slot_s  = slot_of(hit_way_s, idx_s);
  assign vic_dirty_s = !inv_found_s && valid_q[vic_slot_s] && dirty_q[vic_slot_s];
  assign hit_line_s  = data_q[hit_slot_s];
  assign hit_old_s   = word_of(hit_line_s, off_s);
  assign hit_word_s  = req_we_q ? merge_bytes(hit_old_s, req_wdata_q, req_strb_q) : hit_old_s;
  assign fill_old_s  = word_of(i_fetch_data, off_s);
  assign fill_word_s = req_we_q ? merge_bytes(fill_old_s, req_wdata_q, req_strb_q) : fill_old_s;
  assign fill_line_s = put_word(i_fetch_data, off_s, fill_word_s);

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_d       = state_q;
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_fetch_valid = 1'b0;
    o_fetch_ready = 1'b0;
    o_line_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        state_d     = i_req_valid ? S_LOOKUP : S_IDLE;
      end
      S_LOOKUP:     state_d = hit_s ? S_RESPOND : (vic_dirty_s ? S_WRITEBACK : S_FETCH_REQ);
      S_WRITEBACK: begin
        o_line_valid = 1'b1;
        state_d      = i_line_ready ? S_FETCH_REQ : S_WRITEBACK;
      end
      S_FETCH_REQ: begin
        o_fetch_valid = 1'b1;
        state_d       = i_fetch_ready ? S_FETCH_WAIT : S_FETCH_REQ;
      end
      S_FETCH_WAIT: begin
        o_fetch_ready = 1'b1;
        state_d       = i_fetch_valid ? S_RESPOND : S_FETCH_WAIT;
      end
      S_RESPOND: begin
        o_rsp_valid = 1'b1;
        state_d     = i_rsp_ready ? S_IDLE : S_RESPOND;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // Request capture, line state bits, replacement pointer, response word and counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q     <= {LINE_NUM{1'b0}};
      dirty_q     <= {LINE_NUM{1'b0}};
      ptr_q       <= {WAYW{1'b0}};
      req_we_q    <= 1'b0;
      req_addr_q  <= {ADDR_WIDTH{1'b0}};
      req_wdata_q <= {DATA_WIDTH{1'b0}};
      req_strb_q  <= {STRBW{1'b0}};
      vic_slot_q  <= {SLOTW{1'b0}};
      rsp_data_q  <= {DATA_WIDTH{1'b0}};
      line_addr_q <= {ADDR_WIDTH{1'b0}};
      line_data_q <= {LINEW{1'b0}};
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            req_we_q    <= i_req_we;
            req_addr_q  <= i_req_addr;
            req_wdata_q <= i_req_wdata;
            req_strb_q  <= i_req_strb;
          end
        end
        S_LOOKUP: begin
          if (hit_s) begin
            rsp_data_q <= hit_word_s;
            hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (req_we_q) dirty_q[hit_slot_s] <= 1'b1;
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
            vic_slot_q <= vic_slot_s;
            // Victim bundle is frozen here so it stays stable through WRITEBACK.
            if (vic_dirty_s) begin
              line_addr_q <= {tag_q[vic_slot_s], idx_s, {LOW{1'b0}}};
              line_data_q <= data_q[vic_slot_s];
            end
          end
        end
        S_FETCH_WAIT: begin
          if (i_fetch_valid) begin
            valid_q[vic_slot_q] <= 1'b1;
            dirty_q[vic_slot_q] <= req_we_q;
            rsp_data_q          <= fill_word_s;
            ptr_q               <= (ptr_q == WAYW'(WAY_NUM - 1)) ? {WAYW{1'b0}} : ptr_q + WAYW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge i_clk) begin
    if (state_q == S_LOOKUP && hit_s && req_we_q) data_q[hit_slot_s] <= put_word(hit_line_s, off_s, hit_word_s);
    if (state_q == S_FETCH_WAIT && i_fetch_valid) begin
      data_q[vic_slot_q] <= fill_line_s;
      tag_q[vic_slot_q]  <= tag_s;
    end
  end

  assign o_rsp_data   = rsp_data_q;
  assign o_fetch_addr = {tag_s, idx_s, {LOW{1'b0}}};
  assign o_line_addr  = line_addr_q;
  assign o_line_data  = line_data_q;
  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_kv_wb_dcache.sv
// Self-checking bench for kv_wb_dcache (default parameters).
// The reference is a flat memory view (what every load must return) plus a
// per-set residency table (which lines the cache holds, dirty or clean, and
// the global round-robin pointer). The bench also acts as the backing memory.
module tb_kv_wb_dcache;

  localparam int WAYS = 2;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic         i_req_valid = 1'b0, i_req_we = 1'b0, i_rsp_ready = 1'b0;
  logic         i_fetch_ready = 1'b0, i_fetch_valid = 1'b0, i_line_ready = 1'b0;
  logic [31:0]  i_req_addr = 32'd0, i_req_wdata = 32'd0;
  logic [3:0]   i_req_strb = 4'd0;
  logic [127:0] i_fetch_data = 128'd0;
  logic         o_req_ready, o_rsp_valid, o_fetch_valid, o_fetch_ready, o_line_valid;
  logic [31:0]  o_rsp_data, o_fetch_addr, o_line_addr, o_hit_count, o_miss_count;
  logic [127:0] o_line_data;

  kv_wb_dcache dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_strb(i_req_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_fetch_valid(o_fetch_valid), .i_fetch_ready(i_fetch_ready), .o_fetch_addr(o_fetch_addr),
    .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready), .i_fetch_data(i_fetch_data),
    .o_line_valid(o_line_valid), .i_line_ready(i_line_ready), .o_line_addr(o_line_addr),
    .o_line_data(o_line_data), .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] dram [logic [31:0]];
  logic [31:0] gold [logic [31:0]];
  bit          m_v   [WAYS][32];
  bit          m_d   [WAYS][32];
  logic [24:0] m_tag [WAYS][32];
  int          m_ptr;
  logic [31:0] m_hits, m_miss;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] dram_rd(input logic [31:0] a);
    return dram.exists(a) ? dram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] st);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Reset wipes residency; unwritten-back stores are lost, so the expected view reverts to memory.
  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < 32; s++) begin
        m_v[w][s] = 1'b0;
        m_d[w][s] = 1'b0;
        m_tag[w][s] = 25'd0;
      end
    m_ptr = 0;
    m_hits = 32'd0;
    m_miss = 32'd0;
    gold.delete();
    foreach (dram[k]) gold[k] = dram[k];
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_req_ready"}, 128'(o_req_ready), 128'(1'b1));
    check_eq({tag, "_busy"}, 128'({o_rsp_valid, o_fetch_valid, o_fetch_ready, o_line_valid}), 128'(4'd0));
    check_eq({tag, "_counts"}, 128'({o_hit_count, o_miss_count}), 128'(64'd0));
    check_eq({tag, "_buses"}, 128'({o_rsp_data, o_fetch_addr, o_line_addr}), 128'(96'd0));
    check_eq({tag, "_line_data"}, o_line_data, 128'd0);
  endtask

  // One complete request, starting and ending at a falling edge with the cache idle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input int bp, output logic [31:0] rsp);
    logic [4:0]   set;
    logic [24:0]  tag;
    int           hw, vw;
    bit           hit, wb;
    logic [31:0]  exp_rsp, wb_addr, f_addr;
    logic [127:0] wb_line, f_line;
    set = addr[6:2];
    tag = addr[31:7];
    hit = 1'b0; wb = 1'b0; hw = 0; vw = 0;
    wb_addr = 32'd0; wb_line = 128'd0; f_line = 128'd0;
    for (int w = 0; w < WAYS; w++)
      if (m_v[w][set] && m_tag[w][set] == tag) begin hit = 1'b1; hw = w; end
    exp_rsp = we ? merge(gold_rd(addr), wd, st) : gold_rd(addr);
    f_addr = {addr[31:2], 2'b00};
    if (!hit) begin
      vw = m_ptr;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_v[w][set]) vw = w;
      wb = m_v[vw][set] && m_d[vw][set];
      wb_addr = {m_tag[vw][set], set, 2'b00};
      for (int k = 0; k < 4; k++) wb_line[k*32 +: 32] = gold_rd(wb_addr + 32'(k));
    end
    if (we) gold[addr] = exp_rsp;
    if (hit) begin
      m_hits++;
      if (we) m_d[hw][set] = 1'b1;
    end else begin
      m_miss++;
      m_v[vw][set] = 1'b1; m_d[vw][set] = we; m_tag[vw][set] = tag;
      m_ptr = (m_ptr + 1) % WAYS;
    end

    check_eq("req_ready", 128'(o_req_ready), 128'(1'b1));
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wd; i_req_strb = st;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom; i_req_we = ~we;
    check_eq("ready_low", 128'(o_req_ready), 128'(1'b0));
    @(negedge i_clk);
    check_eq("counts", 128'({o_hit_count, o_miss_count}), 128'({m_hits, m_miss}));
    if (!hit) begin
      if (wb) begin
        for (int c = 0; c <= bp; c++) begin
          check_eq("wb_valid", 128'({o_line_valid, o_fetch_valid}), 128'(2'b10));
          check_eq("wb_addr", 128'(o_line_addr), 128'(wb_addr));
          check_eq("wb_data", o_line_data, wb_line);
          if (c < bp) begin
            i_fetch_valid = 1'b1; i_fetch_data = {4{$urandom}};
            @(negedge i_clk);
            i_fetch_valid = 1'b0;
          end
        end
        for (int k = 0; k < 4; k++) dram[wb_addr + 32'(k)] = o_line_data[k*32 +: 32];
        i_line_ready = 1'b1;
        @(negedge i_clk);
        i_line_ready = 1'b0;
      end else begin
        check_eq("no_wb", 128'(o_line_valid), 128'(1'b0));
      end
      for (int c = 0; c <= bp; c++) begin
        check_eq("fetch_valid", 128'(o_fetch_valid), 128'(1'b1));
        check_eq("fetch_addr", 128'(o_fetch_addr), 128'(f_addr));
        check_eq("bp_req_ready", 128'(o_req_ready), 128'(1'b0));
        if (c < bp) @(negedge i_clk);
      end
      i_fetch_ready = 1'b1;
      @(negedge i_clk);
      i_fetch_ready = 1'b0;
      for (int c = 0; c <= bp; c++) begin
        check_eq("fetch_wait", 128'({o_fetch_ready, o_fetch_valid, o_rsp_valid}), 128'(3'b100));
        if (c < bp) @(negedge i_clk);
      end
      for (int k = 0; k < 4; k++) f_line[k*32 +: 32] = dram_rd(f_addr + 32'(k));
      i_fetch_valid = 1'b1; i_fetch_data = f_line;
      @(negedge i_clk);
      i_fetch_valid = 1'b0; i_fetch_data = {4{$urandom}};
    end
    rsp = o_rsp_data;
    for (int c = 0; c <= bp; c++) begin
      check_eq("rsp_valid", 128'({o_rsp_valid, o_req_ready}), 128'(2'b10));
      check_eq("rsp_data", 128'(o_rsp_data), 128'(exp_rsp));
      check_eq("hold_counts", 128'({o_hit_count, o_miss_count}), 128'({m_hits, m_miss}));
      if (c < bp) begin
        i_fetch_valid = 1'b1;
        @(negedge i_clk);
        i_fetch_valid = 1'b0;
      end
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    check_eq("rsp_done", 128'({o_rsp_valid, o_req_ready}), 128'(2'b01));
  endtask

  initial begin
    logic [31:0] r;
    bit found;
    model_reset();
    repeat (3) @(negedge i_clk);
    check_idle("in_rst");
    i_rstn = 1'b1;
    @(negedge i_clk);
    check_idle("post_rst");

    for (int k = 0; k < 4; k++) dram[32'h100 + 32'(k)] = 32'h11 * 32'(k + 1);
    model_reset();
    txn(1'b0, 32'h100, 32'd0, 4'd0, 0, r);
    check_eq("tp_ld100", 128'(r), 128'(32'h11));
    check_eq("tp_miss1", 128'(o_miss_count), 128'(32'd1));
    txn(1'b0, 32'h102, 32'd0, 4'd0, 0, r);
    check_eq("tp_ld102", 128'(r), 128'(32'h33));
    check_eq("tp_hit1", 128'(o_hit_count), 128'(32'd1));
    txn(1'b1, 32'h101, 32'hAABBCCDD, 4'b0011, 0, r);
    check_eq("tp_st101", 128'(r), 128'(32'h0000CCDD));
    txn(1'b0, 32'h101, 32'd0, 4'd0, 0, r);
    check_eq("tp_ld101", 128'(r), 128'(32'h0000CCDD));
    txn(1'b0, 32'h180, 32'd0, 4'd0, 0, r);
    txn(1'b0, 32'h200, 32'd0, 4'd0, 0, r);
    check_eq("tp_wb_word1", 128'(dram_rd(32'h101)), 128'(32'h0000CCDD));
    txn(1'b0, 32'h100, 32'd0, 4'd0, 0, r);
    check_eq("tp_reload", 128'({o_hit_count, o_miss_count}), 128'({32'd3, 32'd4}));

    // Five-cycle backpressure on every handshake, including a dirty eviction.
    txn(1'b1, 32'h180, 32'h12345678, 4'hF, 5, r);
    txn(1'b0, 32'h200, 32'd0, 4'd0, 5, r);
    txn(1'b0, 32'h280, 32'd0, 4'd0, 5, r);
    txn(1'b0, 32'h281, 32'd0, 4'd0, 5, r);

    // Reset while waiting for the fetched line.
    i_line_ready = 1'b1; i_fetch_ready = 1'b1;
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h300;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge i_clk);
      if (o_line_valid) for (int k = 0; k < 4; k++) dram[o_line_addr + 32'(k)] = o_line_data[k*32 +: 32];
      found = o_fetch_ready;
    end
    check_eq("rst_reach_fetch_wait", 128'(found), 128'(1'b1));
    i_line_ready = 1'b0; i_fetch_ready = 1'b0;
    #2 i_rstn = 1'b0;
    #1 check_idle("async_rst");
    i_fetch_valid = 1'b1; i_fetch_data = {4{$urandom}};
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check_idle("stray_fetch");
    i_fetch_valid = 1'b0;
    model_reset();
    txn(1'b0, 32'h100, 32'd0, 4'd0, 0, r);
    check_eq("rst_miss1", 128'({o_hit_count, o_miss_count}), 128'({32'd0, 32'd1}));

    // Random traffic over four tags and two sets to force hits, fills and evictions.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = {23'd0, 2'($urandom_range(0, 3)), 4'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
